// File: rtl/alu_pkg.sv
// Shared types and the ALU evaluation function for the two-slot ALU arbiter.
// Used by the RTL and by the testbench model.
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int ALU_SHW = $clog2(ALU_W);

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_AND  = 2'd1,
        ALU_ASR  = 2'd2,
        ALU_ZERO = 2'd3
    } alu_op_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_FULL = 1'b1
    } arb_state_e;

    function automatic logic [ALU_W-1:0] alu_eval(input alu_op_e op,
                                                  input logic [ALU_W-1:0] a,
                                                  input logic [ALU_W-1:0] b);
        logic [ALU_W-1:0] result;
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_AND:  result = a & b;
            ALU_ASR: begin
                // Any shift of W or more fills the word with the sign bit.
                if (|b[ALU_W-1:ALU_SHW]) result = {ALU_W{a[ALU_W-1]}};
                else                     result = $signed(a) >>> b[ALU_SHW-1:0];
            end
            ALU_ZERO: result = '0;
            default:  result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: the slot that did not win last
// time takes priority when both are valid.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gid
);

    always_comb begin
        gid = 1'b0;
        gnt = 2'b00;
        case (valid)
            2'b01: begin gid = 1'b0; gnt = 2'b01; end
            2'b10: begin gid = 1'b1; gnt = 2'b10; end
            2'b11: begin
                gid = ~last;
                gnt = last ? 2'b01 : 2'b10;
            end
            default: begin gid = 1'b0; gnt = 2'b00; end
        endcase
    end

endmodule

// File: rtl/alu_slot_arbiter.sv
// Shares one ALU between two VLIW issue slots with a registered result stage.
// Optional per-slot / conflict counters are enabled by defining ALU_ARB_STATS_EN.
//
//   state    | meaning
//   ARB_IDLE | result register empty, res_valid=0
//   ARB_FULL | result register holds a result, res_valid=1
module alu_slot_arbiter
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int NSLOT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSLOT-1:0]   req_valid,
    input  logic [2*NSLOT-1:0] req_op,
    input  logic [W*NSLOT-1:0] req_a,
    input  logic [W*NSLOT-1:0] req_b,
    output logic [NSLOT-1:0]   req_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_slot,
    output logic [W-1:0]       res_data,
    output logic               res_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        stat_grant0,
    output logic [15:0]        stat_grant1,
    output logic [15:0]        stat_conflict
`endif
);

    arb_state_e r_state, w_state_nxt;
    logic       r_last;
    logic       r_slot;
    logic [W-1:0] r_data;
    logic       r_zero;

    logic [1:0] w_gnt;
    logic       w_gid;
    logic       w_can_accept;
    logic       w_xfer;
    logic [1:0] w_op_sel;
    logic [W-1:0] w_a_sel, w_b_sel, w_result;

    rr_pick2 u_pick (
        .valid (req_valid),
        .last  (r_last),
        .gnt   (w_gnt),
        .gid   (w_gid)
    );

    // A full register being drained this cycle can be refilled in the same cycle.
    assign w_can_accept = (r_state == ARB_IDLE) | res_ready;
    assign req_ready    = w_gnt & {NSLOT{w_can_accept}};
    assign w_xfer       = |req_ready;

    assign w_op_sel = w_gid ? req_op[3:2]     : req_op[1:0];
    assign w_a_sel  = w_gid ? req_a[2*W-1:W]  : req_a[W-1:0];
    assign w_b_sel  = w_gid ? req_b[2*W-1:W]  : req_b[W-1:0];
    assign w_result = alu_eval(alu_op_e'(w_op_sel), w_a_sel, w_b_sel);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_xfer) w_state_nxt = ARB_FULL;
            ARB_FULL: if (res_ready && !w_xfer) w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
            r_slot  <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_last <= w_gid;
                r_slot <= w_gid;
                r_data <= w_result;
                r_zero <= (w_result == '0);
            end
        end
    end

    assign res_valid = (r_state == ARB_FULL);
    assign res_slot  = r_slot;
    assign res_data  = r_data;
    assign res_zero  = r_zero;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_grant0, r_grant1, r_conflict;
    logic        w_conflict;

    // Both valid and the stage could take one: exactly one slot was turned away.
    assign w_conflict = (&req_valid) & w_can_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant0   <= '0;
            r_grant1   <= '0;
            r_conflict <= '0;
        end else begin
            if (req_ready[0] && r_grant0 != 16'hFFFF)   r_grant0   <= r_grant0 + 16'd1;
            if (req_ready[1] && r_grant1 != 16'hFFFF)   r_grant1   <= r_grant1 + 16'd1;
            if (w_conflict && r_conflict != 16'hFFFF)   r_conflict <= r_conflict + 16'd1;
        end
    end

    assign stat_grant0   = r_grant0;
    assign stat_grant1   = r_grant1;
    assign stat_conflict = r_conflict;
`endif

endmodule
